// File: rtl/hdu_pkg.sv
// Shared types and constants for the HDU authorisation path.
// Credential field widths are fixed here; table and tag widths are module parameters.
package hdu_pkg;

   localparam int FUNC_ID_WIDTH = 8;
   localparam int TOKEN_WIDTH   = 16;

   typedef enum logic [1:0] {
      CFG_WRITE      = 2'd0,
      CFG_INVALIDATE = 2'd1,
      CFG_FLUSH      = 2'd2,
      CFG_NOP        = 2'd3
   } cfg_op_e;

endpackage

// File: rtl/auth_prio_enc.sv
// Lowest-index priority encoder with a multiple-hit flag.
// Purely combinational so it can be shared with other arbitration logic.
module auth_prio_enc #(
   parameter  int N  = 16,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  match_vec,
   output logic          hit,
   output logic [IW-1:0] index,
   output logic          multi
);

   always_comb begin
      hit   = 1'b0;
      index = '0;
      multi = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (match_vec[i]) begin
            if (hit) begin
               multi = 1'b1;
            end else begin
               hit   = 1'b1;
               index = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/auth_cam_ttl.sv
// Credential CAM with per-entry lifetime and a two-stage lookup pipeline.
// Handshakes: a transfer happens on a clock edge where valid and ready are both high.
module auth_cam_ttl
   import hdu_pkg::*;
#(
   parameter  int TABLE_SIZE = 16,
   parameter  int TTL_WIDTH  = 16,
   parameter  int TAG_WIDTH  = 4,
   localparam int IDX_W      = $clog2(TABLE_SIZE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [1:0]               cfg_op,
   input  logic [IDX_W-1:0]         cfg_addr,
   input  logic [FUNC_ID_WIDTH-1:0] cfg_func_id,
   input  logic [TOKEN_WIDTH-1:0]   cfg_token,
   input  logic [TTL_WIDTH-1:0]     cfg_ttl,
   input  logic                     tick,
   input  logic                     lookup_valid,
   output logic                     lookup_ready,
   input  logic [FUNC_ID_WIDTH-1:0] lookup_func_id,
   input  logic [TOKEN_WIDTH-1:0]   lookup_token,
   input  logic [TAG_WIDTH-1:0]     lookup_tag,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_pass,
   output logic [IDX_W-1:0]         rsp_index,
   output logic                     rsp_multi,
   output logic [TAG_WIDTH-1:0]     rsp_tag,
   output logic [IDX_W:0]           valid_count
);

   typedef struct packed {
      logic                 pass;
      logic                 multi;
      logic [IDX_W-1:0]     index;
      logic [TAG_WIDTH-1:0] tag;
   } auth_rsp_t;

   logic [TABLE_SIZE-1:0]    valid_q, valid_d;
   logic [FUNC_ID_WIDTH-1:0] func_q  [TABLE_SIZE];
   logic [FUNC_ID_WIDTH-1:0] func_d  [TABLE_SIZE];
   logic [TOKEN_WIDTH-1:0]   token_q [TABLE_SIZE];
   logic [TOKEN_WIDTH-1:0]   token_d [TABLE_SIZE];
   logic [TTL_WIDTH-1:0]     ttl_q   [TABLE_SIZE];
   logic [TTL_WIDTH-1:0]     ttl_d   [TABLE_SIZE];
   logic [IDX_W:0]           count_q, count_d;

   logic                     s1_valid_q, s1_valid_d;
   logic [FUNC_ID_WIDTH-1:0] s1_func_q, s1_func_d;
   logic [TOKEN_WIDTH-1:0]   s1_token_q, s1_token_d;
   logic [TAG_WIDTH-1:0]     s1_tag_q, s1_tag_d;
   logic                     s2_valid_q, s2_valid_d;
   auth_rsp_t                s2_rsp_q, s2_rsp_d;

   logic                     cfg_fire;
   cfg_op_e                  op;
   logic [TABLE_SIZE-1:0]    match_vec;
   logic                     m_hit, m_multi;
   logic [IDX_W-1:0]         m_index;
   logic                     s1_adv, lookup_fire;

   assign cfg_ready   = !rst;
   assign cfg_fire    = cfg_valid && cfg_ready;
   assign op          = cfg_op_e'(cfg_op);
   assign s1_adv      = s1_valid_q && (!s2_valid_q || rsp_ready);
   assign lookup_ready = !s1_valid_q || s1_adv;
   assign lookup_fire = lookup_valid && lookup_ready;

   // Table update: tick ageing first, then any config command overrides it.
   always_comb begin
      valid_d = valid_q;
      func_d  = func_q;
      token_d = token_q;
      ttl_d   = ttl_q;
      for (int i = 0; i < TABLE_SIZE; i++) begin
         if (tick && valid_q[i] && (ttl_q[i] != '0)) begin
            if (ttl_q[i] == TTL_WIDTH'(1)) begin
               valid_d[i] = 1'b0;
               ttl_d[i]   = '0;
            end else begin
               ttl_d[i] = ttl_q[i] - TTL_WIDTH'(1);
            end
         end
         if (cfg_fire) begin
            case (op)
               CFG_WRITE: begin
                  if (cfg_addr == IDX_W'(i)) begin
                     valid_d[i] = 1'b1;
                     func_d[i]  = cfg_func_id;
                     token_d[i] = cfg_token;
                     ttl_d[i]   = cfg_ttl;
                  end
               end
               CFG_INVALIDATE: begin
                  if (cfg_addr == IDX_W'(i)) begin
                     valid_d[i] = 1'b0;
                     ttl_d[i]   = '0;
                  end
               end
               CFG_FLUSH: begin
                  valid_d[i] = 1'b0;
                  ttl_d[i]   = '0;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      count_d = '0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
         count_d = count_d + (IDX_W + 1)'(valid_q[i]);
      end
   end

   always_comb begin
      match_vec = '0;
      for (int i = 0; i < TABLE_SIZE; i++) begin
         match_vec[i] = valid_q[i] && (func_q[i] == s1_func_q) && (token_q[i] == s1_token_q);
      end
   end

   auth_prio_enc #(.N(TABLE_SIZE)) u_prio (
      .match_vec (match_vec),
      .hit       (m_hit),
      .index     (m_index),
      .multi     (m_multi)
   );

   // S1 holds while S2 is stalled; S2 is loaded only on the transfer edge.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_func_d  = s1_func_q;
      s1_token_d = s1_token_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_rsp_d   = s2_rsp_q;
      if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (lookup_fire) begin
         s1_valid_d = 1'b1;
         s1_func_d  = lookup_func_id;
         s1_token_d = lookup_token;
         s1_tag_d   = lookup_tag;
      end
      if (s1_adv) begin
         s2_valid_d     = 1'b1;
         s2_rsp_d.pass  = m_hit;
         s2_rsp_d.multi = m_multi;
         s2_rsp_d.index = m_index;
         s2_rsp_d.tag   = s1_tag_q;
      end else if (rsp_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         count_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_func_q  <= '0;
         s1_token_q <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_rsp_q   <= '0;
         for (int i = 0; i < TABLE_SIZE; i++) begin
            func_q[i]  <= '0;
            token_q[i] <= '0;
            ttl_q[i]   <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         count_q    <= count_d;
         s1_valid_q <= s1_valid_d;
         s1_func_q  <= s1_func_d;
         s1_token_q <= s1_token_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_rsp_q   <= s2_rsp_d;
         func_q     <= func_d;
         token_q    <= token_d;
         ttl_q      <= ttl_d;
      end
   end

   assign rsp_valid   = s2_valid_q;
   assign rsp_pass    = s2_rsp_q.pass;
   assign rsp_multi   = s2_rsp_q.multi;
   assign rsp_index   = s2_rsp_q.index;
   assign rsp_tag     = s2_rsp_q.tag;
   assign valid_count = count_q;

endmodule

// File: tb/tb_auth_cam_ttl.sv
// Directed bench for auth_cam_ttl: config, ageing, matching, stalls and reset flush.
// Each scenario task drives its own stimulus and checks its own results inline.
module tb_auth_cam_ttl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_op;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_func_id;
   logic [15:0] cfg_token;
   logic [15:0] cfg_ttl;
   logic        tick;
   logic        lookup_valid;
   logic        lookup_ready;
   logic [7:0]  lookup_func_id;
   logic [15:0] lookup_token;
   logic [3:0]  lookup_tag;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_pass;
   logic [3:0]  rsp_index;
   logic        rsp_multi;
   logic [3:0]  rsp_tag;
   logic [4:0]  valid_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Expected response packed as {tag, pass, index}
   logic [8:0] exp_q[$];

   auth_cam_ttl #(.TABLE_SIZE(16), .TTL_WIDTH(16), .TAG_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_op         (cfg_op),
      .cfg_addr       (cfg_addr),
      .cfg_func_id    (cfg_func_id),
      .cfg_token      (cfg_token),
      .cfg_ttl        (cfg_ttl),
      .tick           (tick),
      .lookup_valid   (lookup_valid),
      .lookup_ready   (lookup_ready),
      .lookup_func_id (lookup_func_id),
      .lookup_token   (lookup_token),
      .lookup_tag     (lookup_tag),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_pass       (rsp_pass),
      .rsp_index      (rsp_index),
      .rsp_multi      (rsp_multi),
      .rsp_tag        (rsp_tag),
      .valid_count    (valid_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic cfg_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] f,
                          input logic [15:0] t, input logic [15:0] ttl, input logic with_tick);
      cfg_valid   = 1'b1;
      cfg_op      = op;
      cfg_addr    = addr;
      cfg_func_id = f;
      cfg_token   = t;
      cfg_ttl     = ttl;
      tick        = with_tick;
      step();
      cfg_valid   = 1'b0;
      cfg_op      = 2'd3;
      tick        = 1'b0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   // Presents one request with rsp_ready high; lat counts edges from presentation to rsp_valid.
   task automatic do_lookup(input logic [7:0] f, input logic [15:0] t, input logic [3:0] tg,
                            output logic got, output int lat, output logic p,
                            output logic [3:0] ix, output logic m, output logic [3:0] rt);
      int guard;
      rsp_ready      = 1'b1;
      lookup_func_id = f;
      lookup_token   = t;
      lookup_tag     = tg;
      lookup_valid   = 1'b1;
      guard = 0;
      while (!lookup_ready && guard < 20) begin
         step();
         guard++;
      end
      step();
      lookup_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         step();
         lat++;
      end
      got = rsp_valid;
      p   = rsp_pass;
      ix  = rsp_index;
      m   = rsp_multi;
      rt  = rsp_tag;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      cfg_valid = 1'b0; cfg_op = 2'd3; cfg_addr = '0; cfg_func_id = '0;
      cfg_token = '0; cfg_ttl = '0; tick = 1'b0;
      lookup_valid = 1'b0; lookup_func_id = '0; lookup_token = '0; lookup_tag = '0;
      rsp_ready = 1'b1;
      step(); step();
      tests_run++;
      if (cfg_ready !== 1'b0) begin
         tests_failed++; $display("FAIL reset_cfg_ready_in_rst got=%0b exp=0", cfg_ready);
      end
      rst = 1'b0;
      step();
      tests_run++;
      if ({rsp_valid, rsp_pass, rsp_multi, rsp_index, rsp_tag, valid_count} !== 15'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs got v=%0b p=%0b m=%0b i=%0d t=%0d cnt=%0d exp all 0",
                  rsp_valid, rsp_pass, rsp_multi, rsp_index, rsp_tag, valid_count);
      end
      tests_run++;
      if (cfg_ready !== 1'b1 || lookup_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready got cfg=%0b lk=%0b exp 1 1", cfg_ready, lookup_ready);
      end
   endtask

   task automatic test_basic_match();
      logic got, p, m; int lat; logic [3:0] ix, rt;
      cfg_cmd(2'd0, 4'd3, 8'h12, 16'hABCD, 16'd0, 1'b0);
      tests_run++;
      if (valid_count !== 5'd0) begin
         tests_failed++; $display("FAIL count_lag got=%0d exp=0", valid_count);
      end
      do_lookup(8'h12, 16'hABCD, 4'd5, got, lat, p, ix, m, rt);
      tests_run++;
      if (got !== 1'b1 || lat != 2) begin
         tests_failed++; $display("FAIL basic_latency got valid=%0b lat=%0d exp 1 2", got, lat);
      end
      tests_run++;
      if ({p, m, ix, rt} !== {1'b1, 1'b0, 4'd3, 4'd5}) begin
         tests_failed++;
         $display("FAIL basic_rsp got p=%0b m=%0b i=%0d t=%0d exp 1 0 3 5", p, m, ix, rt);
      end
      tests_run++;
      if (valid_count !== 5'd1) begin
         tests_failed++; $display("FAIL basic_count got=%0d exp=1", valid_count);
      end
   endtask

   task automatic test_mismatch_invalidate();
      logic got, p, m; int lat; logic [3:0] ix, rt;
      do_lookup(8'h12, 16'hABCE, 4'd6, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p, ix} !== {1'b1, 1'b0, 4'd0}) begin
         tests_failed++; $display("FAIL wrong_token got v=%0b p=%0b i=%0d exp 1 0 0", got, p, ix);
      end
      cfg_cmd(2'd1, 4'd3, 8'h00, 16'h0000, 16'd0, 1'b0);
      do_lookup(8'h12, 16'hABCD, 4'd7, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p, ix, rt} !== {1'b1, 1'b0, 4'd0, 4'd7}) begin
         tests_failed++;
         $display("FAIL after_invalidate got v=%0b p=%0b i=%0d t=%0d exp 1 0 0 7", got, p, ix, rt);
      end
      tests_run++;
      if (valid_count !== 5'd0) begin
         tests_failed++; $display("FAIL invalidate_count got=%0d exp=0", valid_count);
      end
   endtask

   task automatic test_multi();
      logic got, p, m; int lat; logic [3:0] ix, rt;
      cfg_cmd(2'd0, 4'd9, 8'h34, 16'h1111, 16'd0, 1'b0);
      cfg_cmd(2'd0, 4'd2, 8'h34, 16'h1111, 16'd0, 1'b0);
      // ttl 0 entries must not age
      pulse_tick(); pulse_tick(); pulse_tick();
      do_lookup(8'h34, 16'h1111, 4'd1, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p, m, ix} !== {1'b1, 1'b1, 1'b1, 4'd2}) begin
         tests_failed++;
         $display("FAIL multi got v=%0b p=%0b m=%0b i=%0d exp 1 1 1 2", got, p, m, ix);
      end
      tests_run++;
      if (valid_count !== 5'd2) begin
         tests_failed++; $display("FAIL multi_count got=%0d exp=2", valid_count);
      end
      cfg_cmd(2'd1, 4'd2, 8'h00, 16'h0000, 16'd0, 1'b0);
      do_lookup(8'h34, 16'h1111, 4'd2, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p, m, ix} !== {1'b1, 1'b1, 1'b0, 4'd9}) begin
         tests_failed++;
         $display("FAIL single_high_index got v=%0b p=%0b m=%0b i=%0d exp 1 1 0 9", got, p, m, ix);
      end
      cfg_cmd(2'd2, 4'd0, 8'h00, 16'h0000, 16'd0, 1'b0);
   endtask

   task automatic test_ttl();
      logic got, p, m; int lat; logic [3:0] ix, rt;
      cfg_cmd(2'd0, 4'd0, 8'h55, 16'h5555, 16'd3, 1'b0);
      pulse_tick(); pulse_tick();
      do_lookup(8'h55, 16'h5555, 4'd3, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p, ix} !== {1'b1, 1'b1, 4'd0}) begin
         tests_failed++; $display("FAIL ttl_alive got v=%0b p=%0b i=%0d exp 1 1 0", got, p, ix);
      end
      pulse_tick();
      do_lookup(8'h55, 16'h5555, 4'd4, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p} !== {1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL ttl_expired got v=%0b p=%0b exp 1 0", got, p);
      end
      // Reload coincides with a tick: the tick must not touch the reloaded entry
      cfg_cmd(2'd0, 4'd0, 8'h55, 16'h5555, 16'd3, 1'b1);
      pulse_tick(); pulse_tick();
      do_lookup(8'h55, 16'h5555, 4'd8, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p} !== {1'b1, 1'b1}) begin
         tests_failed++; $display("FAIL ttl_cfg_wins got v=%0b p=%0b exp 1 1", got, p);
      end
      pulse_tick();
      do_lookup(8'h55, 16'h5555, 4'd9, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p} !== {1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL ttl_reload_expiry got v=%0b p=%0b exp 1 0", got, p);
      end
   endtask

   task automatic test_back_to_back();
      int sent, recv, c;
      logic prev_stall, saw_ready_low, extra;
      logic [8:0] snap, cur, exp;
      cfg_cmd(2'd2, 4'd0, 8'h00, 16'h0000, 16'd0, 1'b0);
      cfg_cmd(2'd0, 4'd5, 8'h5A, 16'h7777, 16'd0, 1'b0);
      step();
      exp_q.delete();
      sent = 0; recv = 0; prev_stall = 1'b0; saw_ready_low = 1'b0; snap = '0;
      for (c = 0; c < 40 && recv < 8; c++) begin
         rsp_ready      = !(c >= 4 && c < 8);
         lookup_valid   = (sent < 8);
         lookup_tag     = 4'(sent);
         lookup_func_id = 8'h5A;
         lookup_token   = (sent % 2 == 0) ? 16'h7777 : 16'h7778;
         #1;
         cur = {rsp_tag, rsp_pass, rsp_index};
         if (prev_stall) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || cur !== snap) begin
               tests_failed++;
               $display("FAIL stall_hold cyc=%0d got v=%0b rsp=%h exp v=1 rsp=%h", c, rsp_valid, cur, snap);
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         snap = cur;
         if (!rsp_ready && sent < 8 && !lookup_ready) saw_ready_low = 1'b1;
         if (rsp_valid && rsp_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
            tests_run++;
            if (cur !== exp) begin
               tests_failed++;
               $display("FAIL stream_rsp n=%0d got {tag,pass,idx}=%h exp=%h", recv, cur, exp);
            end
            recv++;
         end
         if (lookup_valid && lookup_ready) begin
            exp_q.push_back({4'(sent), (sent % 2 == 0), (sent % 2 == 0) ? 4'd5 : 4'd0});
            sent++;
         end
         step();
      end
      lookup_valid = 1'b0;
      rsp_ready    = 1'b1;
      tests_run++;
      if (recv != 8 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL stream_count got recv=%0d pending=%0d exp 8 0", recv, exp_q.size());
      end
      tests_run++;
      if (saw_ready_low !== 1'b1) begin
         tests_failed++; $display("FAIL stall_backpressure got lookup_ready_low=%0b exp=1", saw_ready_low);
      end
      extra = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid) extra = 1'b1;
         step();
      end
      tests_run++;
      if (extra !== 1'b0) begin
         tests_failed++; $display("FAIL stream_duplicate got extra_rsp=%0b exp=0", extra);
      end
   endtask

   task automatic test_flush_and_reset();
      logic got, p, m, stale; int lat; logic [3:0] ix, rt;
      cfg_cmd(2'd0, 4'd7, 8'hC3, 16'hBEEF, 16'd0, 1'b0);
      rsp_ready      = 1'b1;
      lookup_func_id = 8'hC3;
      lookup_token   = 16'hBEEF;
      lookup_tag     = 4'd10;
      lookup_valid   = 1'b1;
      step();
      lookup_valid = 1'b0;
      cfg_valid    = 1'b1;
      cfg_op       = 2'd2;
      step();
      cfg_valid = 1'b0;
      cfg_op    = 2'd3;
      tests_run++;
      if ({rsp_valid, rsp_pass, rsp_index, rsp_tag} !== {1'b1, 1'b1, 4'd7, 4'd10}) begin
         tests_failed++;
         $display("FAIL flush_same_edge got v=%0b p=%0b i=%0d t=%0d exp 1 1 7 10",
                  rsp_valid, rsp_pass, rsp_index, rsp_tag);
      end
      do_lookup(8'hC3, 16'hBEEF, 4'd11, got, lat, p, ix, m, rt);
      tests_run++;
      if ({got, p} !== {1'b1, 1'b0}) begin
         tests_failed++; $display("FAIL after_flush got v=%0b p=%0b exp 1 0", got, p);
      end
      step();
      cfg_cmd(2'd0, 4'd1, 8'h11, 16'h2222, 16'd0, 1'b0);
      lookup_func_id = 8'h11;
      lookup_token   = 16'h2222;
      lookup_tag     = 4'd12;
      lookup_valid   = 1'b1;
      step();
      lookup_tag = 4'd13;
      step();
      lookup_valid = 1'b0;
      rst = 1'b1;
      step();
      tests_run++;
      if (rsp_valid !== 1'b0 || valid_count !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_inflight got v=%0b cnt=%0d exp 0 0", rsp_valid, valid_count);
      end
      rst = 1'b0;
      stale = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (rsp_valid) stale = 1'b1;
      end
      tests_run++;
      if (stale !== 1'b0) begin
         tests_failed++; $display("FAIL reset_stale got stale_rsp=%0b exp=0", stale);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_match();
      test_mismatch_invalidate();
      test_multi();
      test_ttl();
      test_back_to_back();
      test_flush_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
